// File: rtl/quad_input_filter.sv
// quad_input_filter: synchronise and glitch-filter encoder A/B/index pins, flag illegal A/B jumps
module quad_input_filter #(
    parameter int FILT_LEN = 4,
    parameter int PRESCALE = 1,
    parameter int ERR_W    = 8
) (
    input  logic             osc,
    input  logic             rst,
    input  logic             quadA_in,
    input  logic             quadB_in,
    input  logic             index_in,
    input  logic             err_clr,
    output logic             quadA,
    output logic             quadB,
    output logic             index,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);
    localparam int CW = $clog2(FILT_LEN) + 1;
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;

    // channel order in the 3-bit vectors: bit 0 = A, bit 1 = B, bit 2 = index
    logic [2:0]          s1_q, s2_q, out_q, out_d;
    logic [2:0][CW-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]       pcnt_q, pcnt_d;
    logic                sample_en;
    logic                err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]    err_count_q, err_count_d;

    // free-running prescaler; the filters only advance on its wrap cycle
    always_comb begin
        sample_en = pcnt_q == PW'(PRESCALE - 1);
        pcnt_d    = sample_en ? '0 : pcnt_q + PW'(1);
    end

    // per-channel run-length filter: output flips only after FILT_LEN differing samples
    always_comb begin
        out_d = out_q;
        cnt_d = cnt_q;
        for (int c = 0; c < 3; c++) begin
            if (sample_en) begin
                if (s2_q[c] == out_q[c])
                    cnt_d[c] = '0;
                else if (cnt_q[c] < CW'(FILT_LEN - 1))
                    cnt_d[c] = cnt_q[c] + CW'(1);
                else begin
                    out_d[c] = s2_q[c];
                    cnt_d[c] = '0;
                end
            end
        end
    end

    // an A/B step where both filtered channels flip at once is not a legal Gray move;
    // a clear coinciding with a pulse still keeps that event
    always_comb begin
        err_pulse_d = (out_d[0] ^ out_q[0]) & (out_d[1] ^ out_q[1]);
        err_count_d = err_clr ? ERR_W'(err_pulse_q)
                    : (err_pulse_q && err_count_q != '1) ? err_count_q + ERR_W'(1)
                    : err_count_q;
    end

    // all state, cleared asynchronously
    always_ff @(posedge osc or posedge rst) begin
        if (rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            out_q       <= '0;
            cnt_q       <= '0;
            pcnt_q      <= '0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            s1_q        <= {index_in, quadB_in, quadA_in};
            s2_q        <= s1_q;
            out_q       <= out_d;
            cnt_q       <= cnt_d;
            pcnt_q      <= pcnt_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign quadA     = out_q[0];
    assign quadB     = out_q[1];
    assign index     = out_q[2];
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
endmodule
